// File: rtl/ddc_pkg.sv
// Shared widths and helpers for the multi-channel DDC.
// Provides the Q1.15 sin/cos table generator and the output saturation classifier.
package ddc_pkg;

    localparam int QW   = 16;  // Q1.15 coefficient width
    localparam int SATW = 64;  // working width handed to the saturation classifier

    typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_e;

    // round-half-away Q1.15 sample of a full-wave table; elaboration-time only
    function automatic int q15_trig(input int k, input int aw, input bit is_sin);
        real a;
        real v;
        a = 2.0 * 3.141592653589793 * real'(k) / real'(1 << aw);
        v = is_sin ? 32767.0 * $sin(a) : 32767.0 * $cos(a);
        return (v >= 0.0) ? $rtoi(v + 0.5) : $rtoi(v - 0.5);
    endfunction

    function automatic sat_e sat_chk(input logic signed [SATW-1:0] v, input int ow);
        logic signed [SATW-1:0] mx;
        mx = (64'sd1 <<< (ow - 1)) - 64'sd1;
        if (v > mx)  return SAT_POS;
        if (v < ~mx) return SAT_NEG;
        return SAT_NONE;
    endfunction

endpackage

// File: rtl/ddc_nco_lut.sv
// Per-channel NCO: phase accumulator feeding a registered full-wave sin/cos table.
// Address is taken from the phase before the increment; a config load restarts at phase 0.
module ddc_nco_lut
    import ddc_pkg::*;
#(
    parameter int PW    = 32,
    parameter int LUTAW = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clr_i,
    input  logic                 ld_i,
    input  logic                 vld_i,
    input  logic [PW-1:0]        pinc_i,
    input  logic [PW-1:0]        ld_pinc_i,
    output logic signed [QW-1:0] cos_o,
    output logic signed [QW-1:0] sin_o
);

    localparam int N = 1 << LUTAW;

    logic [PW-1:0]        phase_q;
    logic [LUTAW-1:0]     addr_q;
    logic signed [QW-1:0] cos_q, sin_q;
    logic signed [QW-1:0] cos_tab [N];
    logic signed [QW-1:0] sin_tab [N];

    for (genvar k = 0; k < N; k++) begin : g_lut
        localparam logic signed [QW-1:0] CV = QW'(q15_trig(k, LUTAW, 1'b0));
        localparam logic signed [QW-1:0] SV = QW'(q15_trig(k, LUTAW, 1'b1));
        assign cos_tab[k] = CV;
        assign sin_tab[k] = SV;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            phase_q <= '0;
            addr_q  <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else if (clr_i) begin
            phase_q <= '0;
            addr_q  <= '0;
            cos_q   <= '0;
            sin_q   <= '0;
        end else begin
            // a sample arriving with the load is the first of the new block
            if (ld_i) begin
                phase_q <= vld_i ? ld_pinc_i : '0;
                addr_q  <= '0;
            end else if (vld_i) begin
                phase_q <= phase_q + pinc_i;
                addr_q  <= phase_q[PW-1 -: LUTAW];
            end
            cos_q <= cos_tab[addr_q];
            sin_q <= sin_tab[addr_q];
        end
    end

    assign cos_o = cos_q;
    assign sin_o = sin_q;

endmodule

// File: rtl/ddc_mc_top.sv
// Multi-channel DDC: per-channel NCO mix, integrate-and-dump decimation, scale and saturate.
// Define DDC_ROUND_EN for round-half-up on the output shift; default is floor truncation.
module ddc_mc_top
    import ddc_pkg::*;
#(
    parameter int NCH   = 2,
    parameter int DW    = 16,
    parameter int OW    = 16,
    parameter int PW    = 32,
    parameter int LUTAW = 8,
    parameter int DECW  = 8
) (
    input  logic                      CLK,
    input  logic                      RST_N,
    input  logic                      DDCRST,
    input  logic [NCH*DW-1:0]         ADC_DAT,
    input  logic                      ADC_VLD,
    input  logic [NCH*PW-1:0]         CFG_PINC,
    input  logic [DECW-1:0]           CFG_DEC,
    input  logic [$clog2(DECW+1)-1:0] CFG_SHIFT,
    input  logic                      CFG_LD,
    output logic                      DDC_DOE,
    output logic [NCH*OW-1:0]         DDC_DATI,
    output logic [NCH*OW-1:0]         DDC_DATQ,
    output logic [NCH-1:0]            DDC_OVF
);

    localparam int STG = 5;
    localparam int SW  = $clog2(DECW + 1);
    localparam int MW  = DW + 1;
    localparam int AW  = DW + 1 + DECW;
    localparam int PRW = DW + QW;
    localparam logic [SW-1:0] SHMAX = SW'(DECW);
    localparam logic [OW-1:0] OMAX  = {1'b0, {(OW-1){1'b1}}};
    localparam logic [OW-1:0] OMIN  = {1'b1, {(OW-1){1'b0}}};

    logic [NCH-1:0][PW-1:0] pinc_q;
    logic [DECW-1:0]        dec_q, cnt_q, r_m1;
    logic [SW-1:0]          shift_q, sh;
    logic [STG:1]           vld_q;
    logic                   last;

    always_comb begin
        sh   = (shift_q > SHMAX) ? SHMAX : shift_q;
        r_m1 = (dec_q == '0) ? '0 : dec_q - DECW'(1);
        last = (cnt_q == r_m1);
    end

`ifdef DDC_ROUND_EN
    logic signed [AW:0] rnd;
    always_comb begin
        rnd = '0;
        if (sh != '0) rnd[sh - SW'(1)] = 1'b1;
    end
`endif

    // stages: 1 reg/addr, 2 LUT, 3 multiply, 4 accumulate/dump, 5 scale/saturate
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            pinc_q  <= '0;
            dec_q   <= DECW'(1);
            shift_q <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
        end else if (DDCRST) begin
            pinc_q  <= '0;
            dec_q   <= DECW'(1);
            shift_q <= '0;
            cnt_q   <= '0;
            vld_q   <= '0;
        end else if (CFG_LD) begin
            pinc_q  <= CFG_PINC;
            dec_q   <= CFG_DEC;
            shift_q <= CFG_SHIFT;
            cnt_q   <= '0;
            vld_q   <= {{(STG-1){1'b0}}, ADC_VLD};
        end else begin
            vld_q <= {vld_q[4], vld_q[3] & last, vld_q[2], vld_q[1], ADC_VLD};
            if (vld_q[3]) cnt_q <= last ? '0 : cnt_q + DECW'(1);
        end
    end

    assign DDC_DOE = vld_q[STG];

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic signed [QW-1:0]  cos_w, sin_w;
        logic signed [DW-1:0]  x_q, x2_q;
        logic signed [MW-1:0]  mi_q, mq_q;
        logic signed [AW-1:0]  acc_i_q, acc_q_q, dmp_i_q, dmp_q_q;
        logic [OW-1:0]         oi_q, oq_q;
        logic                  ovf_q;
        logic signed [PRW-1:0] pi_w, pq_w;
        logic signed [AW:0]    ai, aq, yi, yq;
        logic [AW-1:0]         mi_x, mq_x;
        sat_e                  si, sq;

        ddc_nco_lut #(.PW(PW), .LUTAW(LUTAW)) u_nco (
            .clk_i     (CLK),
            .rst_ni    (RST_N),
            .clr_i     (DDCRST),
            .ld_i      (CFG_LD),
            .vld_i     (ADC_VLD),
            .pinc_i    (pinc_q[c]),
            .ld_pinc_i (CFG_PINC[c*PW +: PW]),
            .cos_o     (cos_w),
            .sin_o     (sin_w)
        );

        always_comb begin
            pi_w = $signed({{QW{x2_q[DW-1]}}, x2_q}) * $signed({{DW{cos_w[QW-1]}}, cos_w});
            pq_w = -($signed({{QW{x2_q[DW-1]}}, x2_q}) * $signed({{DW{sin_w[QW-1]}}, sin_w}));
            mi_x = {{(AW-MW){mi_q[MW-1]}}, mi_q};
            mq_x = {{(AW-MW){mq_q[MW-1]}}, mq_q};
            ai   = {dmp_i_q[AW-1], dmp_i_q};
            aq   = {dmp_q_q[AW-1], dmp_q_q};
`ifdef DDC_ROUND_EN
            ai   = ai + rnd;
            aq   = aq + rnd;
`endif
            yi   = ai >>> sh;
            yq   = aq >>> sh;
            si   = sat_chk({{(SATW-AW-1){yi[AW]}}, yi}, OW);
            sq   = sat_chk({{(SATW-AW-1){yq[AW]}}, yq}, OW);
        end

        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                x_q <= '0; x2_q <= '0; mi_q <= '0; mq_q <= '0;
                acc_i_q <= '0; acc_q_q <= '0; dmp_i_q <= '0; dmp_q_q <= '0;
                oi_q <= '0; oq_q <= '0; ovf_q <= 1'b0;
            end else if (DDCRST) begin
                x_q <= '0; x2_q <= '0; mi_q <= '0; mq_q <= '0;
                acc_i_q <= '0; acc_q_q <= '0; dmp_i_q <= '0; dmp_q_q <= '0;
                oi_q <= '0; oq_q <= '0; ovf_q <= 1'b0;
            end else begin
                if (ADC_VLD) x_q <= ADC_DAT[c*DW +: DW];
                x2_q <= x_q;
                mi_q <= MW'(pi_w >>> (QW - 1));
                mq_q <= MW'(pq_w >>> (QW - 1));
                if (CFG_LD) begin
                    acc_i_q <= '0;
                    acc_q_q <= '0;
                end else if (vld_q[3]) begin
                    if (last) begin
                        dmp_i_q <= acc_i_q + mi_x;
                        dmp_q_q <= acc_q_q + mq_x;
                        acc_i_q <= '0;
                        acc_q_q <= '0;
                    end else begin
                        acc_i_q <= acc_i_q + mi_x;
                        acc_q_q <= acc_q_q + mq_x;
                    end
                end
                // a dump caught in flight by a config load is dropped entirely
                if (vld_q[4] && !CFG_LD) begin
                    oi_q  <= (si == SAT_POS) ? OMAX : (si == SAT_NEG) ? OMIN : yi[OW-1:0];
                    oq_q  <= (sq == SAT_POS) ? OMAX : (sq == SAT_NEG) ? OMIN : yq[OW-1:0];
                    ovf_q <= ovf_q | (si != SAT_NONE) | (sq != SAT_NONE);
                end
            end
        end

        assign DDC_DATI[c*OW +: OW] = oi_q;
        assign DDC_DATQ[c*OW +: OW] = oq_q;
        assign DDC_OVF[c]           = ovf_q;
    end

endmodule
